// File: rtl/simmem_release_scheduler.sv
// Release scheduler for the simulated-memory bank: one countdown slot per in-flight message,
// per-ID release enables once a slot expires. Define SIMMEM_SCHED_STATS_EN for statistics outputs.
module simmem_release_scheduler #(
  parameter int unsigned IDWidth    = 8,
  parameter int unsigned NumSlots   = 16,
  parameter int unsigned DelayWidth = 8,
  localparam int unsigned NumIds   = 2**IDWidth,
  localparam int unsigned OccWidth = $clog2(NumSlots+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic                  in_ready_i,
  input  logic [IDWidth-1:0]    in_id_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic                  out_valid_i,
  input  logic                  out_ready_i,
  input  logic [IDWidth-1:0]    out_id_i,
  output logic [NumIds-1:0]     release_en_o,
  output logic                  full_o,
  output logic [OccWidth-1:0]   occupancy_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [31:0]           release_count_o,
  output logic [OccWidth-1:0]   max_occupancy_o
);

  logic [NumSlots-1:0]   valid_q, valid_d;
  logic [IDWidth-1:0]    id_q  [NumSlots];
  logic [IDWidth-1:0]    id_d  [NumSlots];
  logic [DelayWidth-1:0] cnt_q [NumSlots];
  logic [DelayWidth-1:0] cnt_d [NumSlots];
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                in_hs, out_hs;
  logic [NumSlots-1:0] expired, alloc_oh, retire_oh;
  logic                alloc_found, retire_found;

  // Both priority encoders look only at registered state, so a slot freed this cycle
  // cannot be reallocated until the next one.
  always_comb begin
    in_hs        = in_valid_i && in_ready_i;
    out_hs       = out_valid_i && out_ready_i;
    expired      = '0;
    alloc_oh     = '0;
    retire_oh    = '0;
    alloc_found  = 1'b0;
    retire_found = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      expired[i] = valid_q[i] && (cnt_q[i] == '0);
      if (!valid_q[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
      if (expired[i] && (id_q[i] == out_id_i) && !retire_found) begin
        retire_oh[i] = 1'b1;
        retire_found = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    overflow_d  = overflow_q  | (in_hs  & ~alloc_found);
    underflow_d = underflow_q | (out_hs & ~retire_found);
    for (int i = 0; i < NumSlots; i++) begin
      id_d[i]  = id_q[i];
      cnt_d[i] = (valid_q[i] && (cnt_q[i] != '0)) ? cnt_q[i] - DelayWidth'(1) : cnt_q[i];
      if (out_hs && retire_oh[i]) begin
        valid_d[i] = 1'b0;
      end
      if (in_hs && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        id_d[i]    = in_id_i;
        cnt_d[i]   = delay_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= id_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    release_en_o = '0;
    occupancy_o  = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (expired[i]) begin
        release_en_o[id_q[i]] = 1'b1;
      end
      occupancy_o = occupancy_o + OccWidth'(valid_q[i]);
    end
  end

  assign full_o      = &valid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

`ifdef SIMMEM_SCHED_STATS_EN
  logic [31:0]         release_count_q, release_count_d;
  logic [OccWidth-1:0] max_occ_q, max_occ_d, occ_next;

  // Peak is taken from next-state occupancy so it never lags the visible occupancy.
  always_comb begin
    occ_next = '0;
    for (int i = 0; i < NumSlots; i++) begin
      occ_next = occ_next + OccWidth'(valid_d[i]);
    end
    release_count_d = release_count_q + 32'(out_hs && retire_found);
    max_occ_d       = (occ_next > max_occ_q) ? occ_next : max_occ_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      release_count_q <= '0;
      max_occ_q       <= '0;
    end else begin
      release_count_q <= release_count_d;
      max_occ_q       <= max_occ_d;
    end
  end

  assign release_count_o = release_count_q;
  assign max_occupancy_o = max_occ_q;
`else
  assign release_count_o = '0;
  assign max_occupancy_o = '0;
`endif

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Self-checking bench for simmem_release_scheduler: an expiry-time model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_simmem_release_scheduler;

  localparam int IDW = 8;
  localparam int NS  = 16;
  localparam int DW  = 8;
  localparam int NID = 256;
  localparam int OW  = 5;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_i = 1'b0;
  logic [IDW-1:0] in_id_i = '0;
  logic [DW-1:0]  delay_i = '0;
  logic           out_valid_i = 1'b0;
  logic           out_ready_i = 1'b0;
  logic [IDW-1:0] out_id_i = '0;
  logic [NID-1:0] release_en_o;
  logic           full_o;
  logic [OW-1:0]  occupancy_o;
  logic           overflow_o;
  logic           underflow_o;
  logic [31:0]    release_count_o;
  logic [OW-1:0]  max_occupancy_o;

  always #5 clk_i = ~clk_i;

  simmem_release_scheduler #(.IDWidth(IDW), .NumSlots(NS), .DelayWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_i(in_ready_i), .in_id_i(in_id_i), .delay_i(delay_i),
    .out_valid_i(out_valid_i), .out_ready_i(out_ready_i), .out_id_i(out_id_i),
    .release_en_o(release_en_o), .full_o(full_o), .occupancy_o(occupancy_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .release_count_o(release_count_o), .max_occupancy_o(max_occupancy_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Model: each slot remembers the absolute cycle at which it becomes releasable.
  bit             m_valid [NS];
  int             m_id    [NS];
  int             m_exp   [NS];
  int             cyc;
  bit             m_ovf, m_unf;
  int             m_rel_count, m_max_occ;
  int             m_ret, m_alc, m_occ;
  bit             m_full;
  logic [NID-1:0] exp_rel;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      m_ovf = 0; m_unf = 0; m_rel_count = 0; m_max_occ = 0; cyc = 0;
    end else begin
      m_ret = -1; m_alc = -1; m_full = 1'b1;
      for (int i = 0; i < NS; i++) begin
        if (!m_valid[i]) m_full = 1'b0;
        if (!m_valid[i] && m_alc < 0) m_alc = i;
        if (m_valid[i] && cyc >= m_exp[i] && m_id[i] == int'(out_id_i) && m_ret < 0) m_ret = i;
      end
      if (in_valid_i && in_ready_i) begin
        if (m_full) m_ovf = 1'b1;
        else begin
          m_valid[m_alc] = 1'b1;
          m_id[m_alc]    = int'(in_id_i);
          m_exp[m_alc]   = cyc + 1 + int'(delay_i);
        end
      end
      if (out_valid_i && out_ready_i) begin
        if (m_ret >= 0) begin
          m_valid[m_ret] = 1'b0;
          m_rel_count++;
        end else m_unf = 1'b1;
      end
      m_occ = 0;
      for (int i = 0; i < NS; i++) if (m_valid[i]) m_occ++;
      if (m_occ > m_max_occ) m_max_occ = m_occ;
      cyc++;
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      exp_rel = '0;
      m_occ = 0;
      for (int i = 0; i < NS; i++) begin
        if (m_valid[i]) begin
          m_occ++;
          if (cyc >= m_exp[i]) exp_rel[m_id[i]] = 1'b1;
        end
      end
      tests_run++;
      if (release_en_o !== exp_rel) begin
        tests_failed++;
        $display("[TB] FAIL model release_en @%0d: got %h, expected %h", cyc, release_en_o, exp_rel);
      end
      checkOutput("model occupancy", 32'(occupancy_o), 32'(m_occ));
      checkOutput("model full", 32'(full_o), 32'(m_occ == NS));
      checkOutput("model overflow", 32'(overflow_o), 32'(m_ovf));
      checkOutput("model underflow", 32'(underflow_o), 32'(m_unf));
`ifdef SIMMEM_SCHED_STATS_EN
      checkOutput("model release_count", release_count_o, 32'(m_rel_count));
      checkOutput("model max_occupancy", 32'(max_occupancy_o), 32'(m_max_occ));
`else
      checkOutput("model release_count", release_count_o, 32'd0);
      checkOutput("model max_occupancy", 32'(max_occupancy_o), 32'd0);
`endif
    end
  end

  task automatic applyStimulus(input bit iv, input int iid, input int d, input bit ov, input int oid);
    in_valid_i  = iv;
    in_ready_i  = iv;
    in_id_i     = IDW'(iid);
    delay_i     = DW'(d);
    out_valid_i = ov;
    out_ready_i = ov;
    out_id_i    = IDW'(oid);
    @(posedge clk_i);
    #2;
    in_valid_i  = 1'b0;
    in_ready_i  = 1'b0;
    out_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    #1;
    checkOutput("reset occupancy", 32'(occupancy_o), 32'd0);
    checkOutput("reset release_any", 32'(|release_en_o), 32'd0);
    checkOutput("reset full", 32'(full_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    doReset();
    idle(10);
    checkOutput("idle release_any", 32'(|release_en_o), 32'd0);
    checkOutput("idle full", 32'(full_o), 32'd0);
    checkOutput("idle occupancy", 32'(occupancy_o), 32'd0);
    checkOutput("idle overflow", 32'(overflow_o), 32'd0);
    checkOutput("idle underflow", 32'(underflow_o), 32'd0);

    // id=3 delay=5: low for cycles 1..5, high at 6, retire at 8
    applyStimulus(1, 3, 5, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      checkOutput("id3 early", 32'(release_en_o[3]), 32'd0);
      idle(1);
    end
    checkOutput("id3 expired", 32'(release_en_o[3]), 32'd1);
    idle(2);
    checkOutput("id3 occupancy before", 32'(occupancy_o), 32'd1);
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("id3 retired", 32'(release_en_o[3]), 32'd0);
    checkOutput("id3 occupancy after", 32'(occupancy_o), 32'd0);

    // id=7 d=0 then d=4; retire first, bit returns at cycle 6
    applyStimulus(1, 7, 0, 0, 0);
    checkOutput("id7 d0 release", 32'(release_en_o[7]), 32'd1);
    applyStimulus(1, 7, 4, 0, 0);
    applyStimulus(0, 0, 0, 1, 7);
    for (int k = 3; k <= 5; k++) begin
      checkOutput("id7 gap", 32'(release_en_o[7]), 32'd0);
      idle(1);
    end
    checkOutput("id7 second release", 32'(release_en_o[7]), 32'd1);
    checkOutput("id7 occupancy", 32'(occupancy_o), 32'd1);
    applyStimulus(0, 0, 0, 1, 7);

    // Fill, then insert while full
    for (int i = 0; i < NS; i++) applyStimulus(1, i, 20, 0, 0);
    checkOutput("fill full", 32'(full_o), 32'd1);
    checkOutput("fill occupancy", 32'(occupancy_o), 32'd16);
    checkOutput("fill no overflow", 32'(overflow_o), 32'd0);
    applyStimulus(1, 1, 20, 0, 0);
    checkOutput("overflow set", 32'(overflow_o), 32'd1);
    checkOutput("overflow occupancy", 32'(occupancy_o), 32'd16);
    checkOutput("overflow id1 untouched", 32'(release_en_o[1]), 32'd0);
    doReset();

    // Full with slot0 expired: simultaneous retire and insert
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i < NS; i++) applyStimulus(1, i, 20, 0, 0);
    checkOutput("slot0 expired", 32'(release_en_o[0]), 32'd1);
    applyStimulus(1, 9, 2, 1, 0);
    checkOutput("simul overflow", 32'(overflow_o), 32'd1);
    checkOutput("simul occupancy", 32'(occupancy_o), 32'd15);
    checkOutput("simul slot0 freed", 32'(release_en_o[0]), 32'd0);
    applyStimulus(1, 9, 2, 0, 0);
    checkOutput("reinsert full", 32'(full_o), 32'd1);
    checkOutput("reinsert id9 pending", 32'(release_en_o[9]), 32'd0);
    idle(2);
    checkOutput("reinsert id9 in slot0", 32'(release_en_o[9]), 32'd1);
    doReset();

    // Three valid retires and one bogus retire
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 1, 4);
    checkOutput("no underflow yet", 32'(underflow_o), 32'd0);
    applyStimulus(0, 0, 0, 1, 5);
    checkOutput("underflow set", 32'(underflow_o), 32'd1);
    checkOutput("underflow occupancy", 32'(occupancy_o), 32'd0);
    idle(3);
    checkOutput("underflow sticky", 32'(underflow_o), 32'd1);
`ifdef SIMMEM_SCHED_STATS_EN
    checkOutput("stats release_count", release_count_o, 32'd3);
    checkOutput("stats max_occupancy", 32'(max_occupancy_o), 32'd3);
`else
    checkOutput("stats release_count tied", release_count_o, 32'd0);
    checkOutput("stats max_occupancy tied", 32'(max_occupancy_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
